mem_port_arbiter: RTL and testbench

- Shares the single 16-bit system memory port between two masters: requester 0 (CVP14 core: instruction fetch, SST, VLD/VST bursts) and requester 1 (host loader/DMA).
- Arbitrates round-robin with burst locking, so a 16-word VLD/VST burst is never split.
- Registers the winner's command onto the memory port and returns read data to the owner with a valid strobe.
- Sits between the core's address/RD/WR outputs and the external memory model.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the external memory model.
// Signal names match the system memory port so the memory model binds directly.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req0;
    logic          req1;
    logic          lock0;
    logic          lock1;
    logic          rd0;
    logic          rd1;
    logic          wr0;
    logic          wr1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          rvalid0;
    logic          rvalid1;
    logic          err;
    logic [AW-1:0] Addr;
    logic          RD;
    logic          WR;
    logic [DW-1:0] DataOut;
    logic [DW-1:0] DataIn;

    modport slave (
        input  req0, req1, lock0, lock1, rd0, rd1, wr0, wr1,
        input  addr0, addr1, wdata0, wdata1, DataIn,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, err,
        output Addr, RD, WR, DataOut
    );

    modport master (
        output req0, req1, lock0, lock1, rd0, rd1, wr0, wr1,
        output addr0, addr1, wdata0, wdata1, DataIn,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, err,
        input  Addr, RD, WR, DataOut
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared 16-bit memory port with burst locking,
// registered memory commands and one-cycle read-data return to the issuing owner.
module mem_port_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MAX_BURST = 16
) (
    input  logic               Clk1,
    input  logic               Reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [4:0] BURST_MAX = 5'(MAX_BURST);

    state_e        state_q,   state_d;
    logic          ptr_q,     ptr_d;
    logic [4:0]    cnt_q,     cnt_d;
    logic          gnt0_q,    gnt0_d;
    logic          gnt1_q,    gnt1_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [DW-1:0] dout_q,    dout_d;
    logic          rd_q,      rd_d;
    logic          wr_q,      wr_d;
    logic          rd_own_q,  rd_own_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic          err_q,     err_d;

    logic          own1_s;
    logic          own_req_s;
    logic          own_lock_s;
    logic          own_rd_s;
    logic          own_wr_s;
    logic          oth_req_s;
    logic [AW-1:0] own_addr_s;
    logic [DW-1:0] own_wdata_s;

    assign own1_s      = (state_q == OWN1);
    assign own_req_s   = own1_s ? bus.req1   : bus.req0;
    assign own_lock_s  = own1_s ? bus.lock1  : bus.lock0;
    assign own_rd_s    = own1_s ? bus.rd1    : bus.rd0;
    assign own_wr_s    = own1_s ? bus.wr1    : bus.wr0;
    assign oth_req_s   = own1_s ? bus.req0   : bus.req1;
    assign own_addr_s  = own1_s ? bus.addr1  : bus.addr0;
    assign own_wdata_s = own1_s ? bus.wdata1 : bus.wdata0;

    // Arbitration, release decision and command capture for the next edge.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        addr_d    = addr_q;
        dout_d    = dout_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        rd_own_d  = rd_own_q;
        err_d     = err_q;
        rvalid0_d = rd_q & ~rd_own_q;
        rvalid1_d = rd_q &  rd_own_q;

        case (state_q)
            IDLE: begin
                // ptr_q holds the last-served requester; requester 0 wins ties unless it was last
                if (bus.req0 && (!bus.req1 || ptr_q)) begin
                    state_d = OWN0;
                    ptr_d   = 1'b0;
                    cnt_d   = 5'd0;
                    gnt0_d  = 1'b1;
                end else if (bus.req1) begin
                    state_d = OWN1;
                    ptr_d   = 1'b1;
                    cnt_d   = 5'd0;
                    gnt1_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0, OWN1: begin
                if (!own_req_s || ((cnt_q == BURST_MAX) && !own_lock_s && oth_req_s)) begin
                    state_d = IDLE;
                end else begin
                    gnt0_d = ~own1_s;
                    gnt1_d =  own1_s;
                    if (own_rd_s || own_wr_s) begin
                        addr_d   = own_addr_s;
                        dout_d   = own_wdata_s;
                        rd_d     = own_rd_s & ~own_wr_s;
                        wr_d     = own_wr_s;
                        rd_own_d = own1_s;
                        if (cnt_q != BURST_MAX) begin
                            cnt_d = cnt_q + 5'd1;
                        end else begin
                            cnt_d = cnt_q;
                        end
                        if (own_rd_s && own_wr_s) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b1;
            cnt_q     <= 5'd0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_own_q  <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            rd_own_q  <= rd_own_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err_q     <= err_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.Addr    = addr_q;
    assign bus.DataOut = dout_q;
    assign bus.RD      = rd_q;
    assign bus.WR      = wr_q;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.err     = err_q;
    // Read data is shared; rvalidN alone identifies the recipient.
    assign bus.rdata0  = bus.DataIn;
    assign bus.rdata1  = bus.DataIn;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single read, locked burst,
// preemption, round-robin alternation, rd+wr error and mid-burst reset.
module tb_mem_port_arbiter;
    logic Clk1;
    logic Reset;
    int   n_checks;
    int   n_fail;

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_port_arbiter #(.AW(16), .DW(16), .MAX_BURST(16)) dut (
        .Clk1  (Clk1),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    function automatic logic [15:0] memval(input logic [15:0] a);
        if (a == 16'h0040) return 16'hBEEF;
        else               return a ^ 16'h5A5A;
    endfunction

    // Memory model: data appears the cycle after RD
    always @(posedge Clk1) begin
        if (!Reset)      bus.DataIn <= 16'h0000;
        else if (bus.RD) bus.DataIn <= memval(bus.Addr);
        else             bus.DataIn <= 16'h0000;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk1);
        #1;
    endtask

    initial begin
        logic [15:0] a;
        int w;
        n_checks = 0;
        n_fail   = 0;
        Reset = 1'b0;
        bus.req0 = 1'b1;  bus.req1 = 1'b1;
        bus.lock0 = 1'b0; bus.lock1 = 1'b0;
        bus.rd0 = 1'b0;   bus.rd1 = 1'b0;
        bus.wr0 = 1'b0;   bus.wr1 = 1'b0;
        bus.addr0 = 16'h0000;  bus.addr1 = 16'h0000;
        bus.wdata0 = 16'h0000; bus.wdata1 = 16'h0000;

        // Reset held with both requesting
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_gnt0", 32'(bus.gnt0), 32'h0);
            check_eq("rst_gnt1", 32'(bus.gnt1), 32'h0);
            check_eq("rst_rd", 32'(bus.RD), 32'h0);
            check_eq("rst_wr", 32'(bus.WR), 32'h0);
            check_eq("rst_err", 32'(bus.err), 32'h0);
            check_eq("rst_rv0", 32'(bus.rvalid0), 32'h0);
            check_eq("rst_rv1", 32'(bus.rvalid1), 32'h0);
            check_eq("rst_addr", 32'(bus.Addr), 32'h0);
            check_eq("rst_dout", 32'(bus.DataOut), 32'h0);
        end
        Reset = 1'b1;
        step();
        check_eq("tie_gnt0", 32'(bus.gnt0), 32'h1);
        check_eq("tie_gnt1", 32'(bus.gnt1), 32'h0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step();
        check_eq("tie_rel_gnt0", 32'(bus.gnt0), 32'h0);

        // Single read
        bus.req0 = 1'b1; bus.rd0 = 1'b1; bus.addr0 = 16'h0040;
        step();
        check_eq("rd_gnt0", 32'(bus.gnt0), 32'h1);
        check_eq("rd_nostrobe", 32'(bus.RD), 32'h0);
        step();
        check_eq("rd_strobe", 32'(bus.RD), 32'h1);
        check_eq("rd_addr", 32'(bus.Addr), 32'h0040);
        check_eq("rd_rv0_early", 32'(bus.rvalid0), 32'h0);
        bus.req0 = 1'b0; bus.rd0 = 1'b0;
        step();
        check_eq("rd_rv0", 32'(bus.rvalid0), 32'h1);
        check_eq("rd_rdata0", 32'(bus.rdata0), 32'hBEEF);
        check_eq("rd_rv1", 32'(bus.rvalid1), 32'h0);
        check_eq("rd_rel_rd", 32'(bus.RD), 32'h0);
        check_eq("rd_rel_gnt0", 32'(bus.gnt0), 32'h0);
        step();
        check_eq("rd_rv0_done", 32'(bus.rvalid0), 32'h0);

        // Locked 16-beat burst from requester 0, requester 1 waiting
        bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.rd0 = 1'b1; bus.addr0 = 16'h0100;
        step();
        check_eq("vld_gnt0", 32'(bus.gnt0), 32'h1);
        for (int i = 0; i < 16; i++) begin
            a = 16'h0100 + 16'(i);
            bus.addr0 = a;
            if (i == 3) bus.req1 = 1'b1;
            step();
            check_eq("vld_rd", 32'(bus.RD), 32'h1);
            check_eq("vld_addr", 32'(bus.Addr), 32'(a));
            check_eq("vld_gnt1", 32'(bus.gnt1), 32'h0);
            if (i > 0) begin
                check_eq("vld_rv0", 32'(bus.rvalid0), 32'h1);
                check_eq("vld_rdata", 32'(bus.rdata0), 32'(memval(a - 16'h0001)));
            end
        end
        bus.rd0 = 1'b0;
        step();
        check_eq("vld_hold_gnt0", 32'(bus.gnt0), 32'h1);
        check_eq("vld_hold_gnt1", 32'(bus.gnt1), 32'h0);
        check_eq("vld_hold_rd", 32'(bus.RD), 32'h0);
        check_eq("vld_last_rv0", 32'(bus.rvalid0), 32'h1);
        check_eq("vld_last_rdata", 32'(bus.rdata0), 32'(memval(16'h010F)));
        bus.req0 = 1'b0; bus.lock0 = 1'b0;
        step();
        check_eq("vld_dead_gnt0", 32'(bus.gnt0), 32'h0);
        check_eq("vld_dead_gnt1", 32'(bus.gnt1), 32'h0);
        step();
        check_eq("vld_hand_gnt1", 32'(bus.gnt1), 32'h1);
        check_eq("vld_hand_gnt0", 32'(bus.gnt0), 32'h0);

        // Preemption of unlocked writer 1 after 16 beats
        bus.wr1 = 1'b1;
        for (int j = 0; j < 16; j++) begin
            a = 16'h0200 + 16'(j);
            bus.addr1 = a;
            bus.wdata1 = 16'h1000 + 16'(j);
            if (j == 4) bus.req0 = 1'b1;
            step();
            check_eq("pre_wr", 32'(bus.WR), 32'h1);
            check_eq("pre_rd", 32'(bus.RD), 32'h0);
            check_eq("pre_addr", 32'(bus.Addr), 32'(a));
            check_eq("pre_dout", 32'(bus.DataOut), 32'(16'h1000 + 16'(j)));
            check_eq("pre_gnt1", 32'(bus.gnt1), 32'h1);
        end
        bus.addr1 = 16'h0210; bus.wdata1 = 16'h1010;
        step();
        check_eq("pre_drop_gnt1", 32'(bus.gnt1), 32'h0);
        check_eq("pre_drop_gnt0", 32'(bus.gnt0), 32'h0);
        check_eq("pre_drop_wr", 32'(bus.WR), 32'h0);
        step();
        check_eq("pre_gnt0", 32'(bus.gnt0), 32'h1);
        check_eq("pre_gnt1_low", 32'(bus.gnt1), 32'h0);
        check_eq("pre_no17_a", 32'(bus.WR), 32'h0);
        bus.req0 = 1'b0;
        step();
        check_eq("pre_idle_gnt0", 32'(bus.gnt0), 32'h0);
        check_eq("pre_no17_b", 32'(bus.WR), 32'h0);
        step();
        check_eq("pre_regain_gnt1", 32'(bus.gnt1), 32'h1);
        check_eq("pre_no17_c", 32'(bus.WR), 32'h0);
        step();
        check_eq("pre_w17", 32'(bus.WR), 32'h1);
        check_eq("pre_w17_addr", 32'(bus.Addr), 32'h0210);
        check_eq("pre_w17_dout", 32'(bus.DataOut), 32'h1010);
        bus.wr1 = 1'b0; bus.req1 = 1'b0;
        step();
        check_eq("pre_end_gnt1", 32'(bus.gnt1), 32'h0);

        // Round-robin with single beats
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = k % 2;
            step();
            check_eq("rr_gnt0", 32'(bus.gnt0), (w == 0) ? 32'h1 : 32'h0);
            check_eq("rr_gnt1", 32'(bus.gnt1), (w == 1) ? 32'h1 : 32'h0);
            a = 16'h0300 + 16'(k);
            if (w == 0) begin bus.rd0 = 1'b1; bus.addr0 = a; end
            else        begin bus.rd1 = 1'b1; bus.addr1 = a; end
            step();
            check_eq("rr_rd", 32'(bus.RD), 32'h1);
            check_eq("rr_addr", 32'(bus.Addr), 32'(a));
            if (w == 0) begin bus.req0 = 1'b0; bus.rd0 = 1'b0; end
            else        begin bus.req1 = 1'b0; bus.rd1 = 1'b0; end
            step();
            check_eq("rr_gap_gnt0", 32'(bus.gnt0), 32'h0);
            check_eq("rr_gap_gnt1", 32'(bus.gnt1), 32'h0);
            if (w == 0) check_eq("rr_rv0", 32'(bus.rvalid0), 32'h1);
            else        check_eq("rr_rv1", 32'(bus.rvalid1), 32'h1);
            if (k < 3) begin
                if (w == 0) bus.req0 = 1'b1;
                else        bus.req1 = 1'b1;
            end
        end
        bus.req0 = 1'b0;

        // rd and wr together: write wins, err is sticky
        check_eq("err_pre", 32'(bus.err), 32'h0);
        bus.req0 = 1'b1;
        step();
        check_eq("err_gnt0", 32'(bus.gnt0), 32'h1);
        bus.rd0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 16'h0005; bus.wdata0 = 16'h1234;
        step();
        check_eq("err_wr", 32'(bus.WR), 32'h1);
        check_eq("err_rd", 32'(bus.RD), 32'h0);
        check_eq("err_dout", 32'(bus.DataOut), 32'h1234);
        check_eq("err_addr", 32'(bus.Addr), 32'h0005);
        check_eq("err_set", 32'(bus.err), 32'h1);
        bus.rd0 = 1'b0; bus.wr0 = 1'b0; bus.req0 = 1'b0;
        step();
        check_eq("err_sticky1", 32'(bus.err), 32'h1);
        check_eq("err_no_rv0", 32'(bus.rvalid0), 32'h0);
        step();
        check_eq("err_sticky2", 32'(bus.err), 32'h1);
        Reset = 1'b0;
        step();
        check_eq("err_clear", 32'(bus.err), 32'h0);
        Reset = 1'b1;

        // Reset mid-burst discards the pending read return
        bus.req0 = 1'b1; bus.rd0 = 1'b1; bus.addr0 = 16'h0040;
        step();
        check_eq("mid_gnt0", 32'(bus.gnt0), 32'h1);
        step();
        check_eq("mid_rd", 32'(bus.RD), 32'h1);
        Reset = 1'b0;
        step();
        check_eq("mid_rv0", 32'(bus.rvalid0), 32'h0);
        check_eq("mid_rd_clr", 32'(bus.RD), 32'h0);
        check_eq("mid_gnt0_clr", 32'(bus.gnt0), 32'h0);
        Reset = 1'b1; bus.req0 = 1'b0; bus.rd0 = 1'b0;
        step();
        check_eq("mid_rv0_after", 32'(bus.rvalid0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
